// File: rtl/mm_bank_scheduler.sv
// Ping-pong controller for the two-bank ring-shift operand memory of the systolic array.
// One bank streams into the array while the host fills the other; banks swap at phase boundaries.
module mm_bank_scheduler #(
    parameter int N  = 2,
    parameter int S  = 4,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [TW-1:0] num_tiles,
    input  logic          tile_valid,
    output logic          tile_ready,
    output logic          load_en,
    output logic          sel,
    output logic          shift_en,
    output logic          clr_acc,
    output logic          result_valid,
    output logic [TW-1:0] result_idx,
    output logic          busy,
    output logic          done
);

    localparam int PH = 3*S - 2;
    localparam int CW = (PH > 1 && N > 0) ? $clog2(PH) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(PH - 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(S - 1);

    typedef enum logic [2:0] {IDLE, FILL, RUN, WAIT, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [TW-1:0] acc_cnt, acc_n;
    logic [TW-1:0] cmp_cnt, cmp_n;
    logic [TW-1:0] ntiles, ntiles_n;
    logic          shadow_full, sf_n;
    logic          sel_q, sel_n;
    logic          accept;

    assign sel = sel_q;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        acc_n        = acc_cnt;
        cmp_n        = cmp_cnt;
        ntiles_n     = ntiles;
        sf_n         = shadow_full;
        sel_n        = sel_q;
        shift_en     = 1'b0;
        clr_acc      = 1'b0;
        result_valid = 1'b0;
        result_idx   = '0;
        busy         = (state != IDLE);
        done         = (state == DONE);
        tile_ready   = ((state == FILL) || (state == RUN) || (state == WAIT))
                       && !shadow_full && (acc_cnt < ntiles);
        accept       = tile_valid && tile_ready;
        load_en      = accept;

        if (accept)
            acc_n = acc_cnt + TW'(1);

        case (state)
            IDLE: begin
                if (start) begin
                    ntiles_n = num_tiles;
                    acc_n    = '0;
                    cmp_n    = '0;
                    sf_n     = 1'b0;
                    cnt_n    = '0;
                    state_n  = (num_tiles == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    sel_n   = !sel_q;
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                shift_en = (cnt <= SHIFT_LAST);
                clr_acc  = (cnt == '0);
                if (accept)
                    sf_n = 1'b1;
                if (cnt == CNT_LAST) begin
                    result_valid = 1'b1;
                    result_idx   = cmp_cnt;
                    cmp_n        = cmp_cnt + TW'(1);
                    // A tile written this very cycle lands before the swap, so it counts as ready.
                    if (shadow_full || accept) begin
                        sel_n = !sel_q;
                        cnt_n = '0;
                        sf_n  = 1'b0;
                    end else if (cmp_cnt + TW'(1) == ntiles) begin
                        cnt_n   = '0;
                        state_n = DONE;
                    end else begin
                        state_n = WAIT;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT: begin
                if (accept) begin
                    sel_n   = !sel_q;
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_cnt     <= '0;
            cmp_cnt     <= '0;
            ntiles      <= '0;
            shadow_full <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            acc_cnt     <= acc_n;
            cmp_cnt     <= cmp_n;
            ntiles      <= ntiles_n;
            shadow_full <= sf_n;
            sel_q       <= sel_n;
        end
    end

endmodule

// File: tb/tb_mm_bank_scheduler.sv
// Scenario bench for mm_bank_scheduler (S=4, PH=10): result/done events checked through a
// cycle-stamped scoreboard, per-cycle control outputs checked directly.
module tb_mm_bank_scheduler;

    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [TW-1:0] num_tiles = '0;
    logic          tile_valid = 1'b0;
    logic          tile_ready, load_en, sel, shift_en, clr_acc, result_valid, busy, done;
    logic [TW-1:0] result_idx;

    mm_bank_scheduler #(.N(2), .S(4), .TW(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .load_en(load_en),
        .sel(sel), .shift_en(shift_en), .clr_acc(clr_acc),
        .result_valid(result_valid), .result_idx(result_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [TW-1:0] idx;
        int          cyc;
    } ev_t;

    ev_t sbq[$];
    int  cyc = 0;
    int  nchecks = 0;
    int  nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // advance to the sampling point (negedge) of cycle c
    task automatic at(input int c);
        run_to(c);
        @(negedge clk);
    endtask

    task automatic push_res(input int idx, input int c);
        ev_t e;
        e.is_done = 1'b0; e.idx = TW'(idx); e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic push_done(input int c);
        ev_t e;
        e.is_done = 1'b1; e.idx = '0; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_sel"}, sel, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_tready"}, tile_ready, 1'b0);
        check({tag, "_load"}, load_en, 1'b0);
        check({tag, "_shift"}, shift_en, 1'b0);
        check({tag, "_clr"}, clr_acc, 1'b0);
        check({tag, "_rv"}, result_valid, 1'b0);
        check({tag, "_ridx"}, result_idx, '0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    always @(negedge clk) begin
        if (result_valid || done) begin
            if (sbq.size() == 0) begin
                check("unexpected_event", {result_valid, done}, 2'b00);
            end else begin
                ev_t e;
                e = sbq.pop_front();
                check("ev_kind", done, e.is_done);
                check("ev_cyc", cyc, e.cyc);
                if (!e.is_done) check("res_idx", result_idx, e.idx);
            end
        end
    end

    initial begin
        // reset and idle
        at(2);
        check_quiet("rst");
        run_to(3); rst = 1'b0;
        at(4);
        check_quiet("idle");

        // one tile: accept at 7, result 17, done 18
        run_to(6); start = 1'b1; num_tiles = 8'd1; tile_valid = 1'b1;
        push_res(0, 17); push_done(18);
        run_to(7); start = 1'b0;
        at(7);
        check("t1_load", load_en, 1'b1);
        check("t1_sel_pre", sel, 1'b0);
        at(8);
        check("t1_sel", sel, 1'b1);
        check("t1_clr", clr_acc, 1'b1);
        check("t1_shift0", shift_en, 1'b1);
        check("t1_noload", load_en, 1'b0);
        at(11);
        check("t1_shift3", shift_en, 1'b1);
        at(12);
        check("t1_shift4", shift_en, 1'b0);
        check("t1_clr_off", clr_acc, 1'b0);
        at(18);
        check("t1_busy_done", busy, 1'b1);
        at(19);
        check("t1_busy_low", busy, 1'b0);
        tile_valid = 1'b0;

        // three tiles back-to-back, sel starts at 1; start while busy ignored
        run_to(22); start = 1'b1; num_tiles = 8'd3; tile_valid = 1'b1;
        push_res(0, 33); push_res(1, 43); push_res(2, 53); push_done(54);
        run_to(23); start = 1'b0;
        at(24);
        check("t3_sel0", sel, 1'b0);
        run_to(28); start = 1'b1; num_tiles = 8'd7;
        run_to(29); start = 1'b0;
        at(34);
        check("t3_sel1", sel, 1'b1);
        check("t3_load3", load_en, 1'b1);
        at(44);
        check("t3_sel2", sel, 1'b0);
        check("t3_no_extra", tile_ready, 1'b0);
        at(55);
        check("t3_busy_low", busy, 1'b0);
        tile_valid = 1'b0;

        // two tiles, second late: WAIT from 70, accept at 74
        run_to(58); start = 1'b1; num_tiles = 8'd2; tile_valid = 1'b1;
        push_res(0, 69); push_res(1, 84); push_done(85);
        run_to(59); start = 1'b0;
        run_to(60); tile_valid = 1'b0;
        at(60);
        check("tw_sel", sel, 1'b1);
        at(72);
        check("tw_shift", shift_en, 1'b0);
        check("tw_busy", busy, 1'b1);
        check("tw_tready", tile_ready, 1'b1);
        check("tw_clr", clr_acc, 1'b0);
        run_to(74); tile_valid = 1'b1;
        at(74);
        check("tw_load", load_en, 1'b1);
        check("tw_sel_hold", sel, 1'b1);
        at(75);
        check("tw_clr_run", clr_acc, 1'b1);
        check("tw_sel_swap", sel, 1'b0);
        check("tw_shift_run", shift_en, 1'b1);
        run_to(76); tile_valid = 1'b0;
        at(86);
        check("tw_busy_low", busy, 1'b0);

        // zero-tile job
        run_to(90); start = 1'b1; num_tiles = 8'd0;
        push_done(91);
        run_to(91); start = 1'b0;
        at(91);
        check("t0_tready", tile_ready, 1'b0);
        check("t0_busy", busy, 1'b1);
        check("t0_sel", sel, 1'b0);
        at(92);
        check("t0_busy_low", busy, 1'b0);

        // abort at cnt=5, then a fresh one-tile job from sel=0
        run_to(95); start = 1'b1; num_tiles = 8'd2; tile_valid = 1'b1;
        run_to(96); start = 1'b0;
        at(96);
        check("ab_load", load_en, 1'b1);
        run_to(102); rst = 1'b1;
        at(102);
        check("ab_shift5", shift_en, 1'b0);
        check("ab_sel", sel, 1'b1);
        run_to(103); rst = 1'b0;
        at(103);
        check_quiet("ab_post");
        run_to(105); start = 1'b1; num_tiles = 8'd1;
        push_res(0, 116); push_done(117);
        run_to(106); start = 1'b0;
        at(106);
        check("fr_sel_pre", sel, 1'b0);
        check("fr_load", load_en, 1'b1);
        at(107);
        check("fr_sel", sel, 1'b1);
        check("fr_clr", clr_acc, 1'b1);
        at(119);
        check("fr_busy_low", busy, 1'b0);
        tile_valid = 1'b0;

        at(121);
        check("sb_drain", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
